// File: rtl/aes_encrypt_driver.sv
// aes_encrypt_driver: host-side initiator for the byte-serial AES encryption
// core. Takes a 128-bit key/plaintext on a valid/ready port, streams both
// into the core one byte per cycle, waits for the core's ready, collects the
// 16 ciphertext bytes and offers the 128-bit result on a valid/ready port.
// Optional macro AES_DRV_TIMEOUT_EN bounds the WAIT state by TIMEOUT_CYCLES
// and reports an expired block on err.
module aes_encrypt_driver #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err,
  output logic         core_enable,
  output logic [7:0]   core_key_byte,
  output logic [7:0]   core_state_byte,
  input  logic         core_load,
  input  logic         core_ready,
  input  logic [7:0]   core_state_out_byte
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Byte 15 is on the bus while cnt is 16; the core captures it on that edge.
  localparam logic [4:0] LOAD_LAST  = 5'd16;
  localparam logic [4:0] DRAIN_LAST = 5'd15;
  localparam logic [4:0] GAP_LAST   = 5'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 2 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("aes_encrypt_driver: GAP_CYCLES must be in 2..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("aes_encrypt_driver: TIMEOUT_CYCLES must be at least 1");
  end

  state_t         r_state;
  state_t         w_state_next;
  logic [4:0]     r_cnt;
  logic           r_armed;
  logic           r_enable;
  logic           r_out_valid;
  logic           r_busy;
  logic [127:0]   r_key_sr;
  logic [127:0]   r_text_sr;
  logic [127:0]   r_out_data;

  logic           w_accept;
  logic           w_store;
  logic           w_drain_done;
  logic           w_out_hs;
  logic           w_timeout;
  logic           w_start_drain;

  // Stale ready from the previous block is only trusted after one low sample.
  assign w_start_drain = (r_state == ST_WAIT) && r_armed && core_ready;

`ifdef AES_DRV_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_WAIT) && !w_start_drain && (r_to_cnt == TO_LAST);

  // WAIT-state watchdog and the one-cycle err pulse it produces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_WAIT) ? r_to_cnt + 1'b1 : '0;
      r_err    <= w_timeout;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register; reset lands in GAP so the core sees enable low first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GAP;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and single-cycle datapath strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_store      = 1'b0;
    w_drain_done = 1'b0;
    w_out_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_cnt == LOAD_LAST) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_start_drain) w_state_next = ST_DRAIN;
        else if (w_timeout) w_state_next = ST_GAP;
      end
      ST_DRAIN: begin
        w_store = 1'b1;
        if (r_cnt == DRAIN_LAST) begin
          w_drain_done = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_out_hs     = 1'b1;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_GAP;
    endcase
  end

  // Datapath: shared counter, byte shifters, enable, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with <= only, so every register in this block
    // sees the pre-edge values of its neighbours regardless of statement order.
    if (!rst_n) begin
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_enable    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_key_sr    <= '0;
      r_text_sr   <= '0;
      r_out_data  <= '0;
    end else begin
      // The counter restarts from 0 on every state change.
      r_cnt <= (w_state_next != r_state) ? 5'd0 : r_cnt + 5'd1;

      if (r_state != ST_WAIT) r_armed <= 1'b0;
      else if (!core_ready)   r_armed <= 1'b1;

      if (w_accept)                       r_enable <= 1'b1;
      else if (w_drain_done || w_timeout) r_enable <= 1'b0;

      // Byte 0 is shown for two cycles, then one new byte per edge.
      if (w_accept) begin
        r_key_sr  <= in_key;
        r_text_sr <= in_text;
      end else if (r_state == ST_LOAD && r_cnt >= 5'd1 && r_cnt <= 5'd15) begin
        r_key_sr  <= {r_key_sr[119:0], 8'h00};
        r_text_sr <= {r_text_sr[119:0], 8'h00};
      end

      // After 16 shifts the first received byte sits in [127:120].
      if (w_store) r_out_data <= {r_out_data[119:0], core_state_out_byte};

      if (w_drain_done)  r_out_valid <= 1'b1;
      else if (w_out_hs) r_out_valid <= 1'b0;

      if (w_accept)                      r_busy <= 1'b1;
      else if (w_state_next == ST_IDLE)  r_busy <= 1'b0;
    end
  end

  assign in_ready        = (r_state == ST_IDLE);
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign busy            = r_busy;
  assign core_enable     = r_enable;
  assign core_key_byte   = r_key_sr[127:120];
  assign core_state_byte = r_text_sr[127:120];

  // The core only raises load while it is capturing our bytes.
  a_load_in_load : assert property (@(posedge clk) disable iff (!rst_n)
    core_load |-> (r_state == ST_LOAD));

endmodule

// File: tb/tb_aes_encrypt_driver.sv
// Directed bench for aes_encrypt_driver with a behavioural byte-serial core.
// The core model captures key/text bytes on the documented edges and returns
// a ciphertext after a fixed latency (FIPS-197 vector answered by table).
`timescale 1ns/1ps
module tb_aes_encrypt_driver;

  localparam int GAP = 2;
  localparam int LAT = 6;
  localparam int TO  = 255;

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic [127:0] in_text = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;
  logic         err;
  logic         core_enable;
  logic [7:0]   core_key_byte;
  logic [7:0]   core_state_byte;
  logic         core_load = 1'b0;
  logic         core_ready = 1'b0;
  logic [7:0]   core_state_out_byte = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  aes_encrypt_driver #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_key              (in_key),
    .in_text             (in_text),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .busy                (busy),
    .err                 (err),
    .core_enable         (core_enable),
    .core_key_byte       (core_key_byte),
    .core_state_byte     (core_state_byte),
    .core_load           (core_load),
    .core_ready          (core_ready),
    .core_state_out_byte (core_state_out_byte)
  );

  always #5 clk = ~clk;

  // Stand-in cipher of the core model: FIPS vector by table, else a
  // byte-position-sensitive mix of key and half-swapped text.
  function automatic logic [127:0] core_cipher(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_TEXT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
  endfunction

  // ---------------- core model ----------------
  int           b_phase = 0;
  int           b_k = 0;
  int           b_t = 0;
  int           b_restarts = 0;
  bit           stale_mode = 1'b0;
  bit           never_ready = 1'b0;
  logic [127:0] cap_key = '0;
  logic [127:0] cap_text = '0;
  logic [127:0] b_res = '0;

  always @(posedge clk) begin
    if (!core_enable) begin
      b_phase   <= 0;
      core_load <= 1'b0;
      if (!stale_mode) core_ready <= 1'b0;
    end else begin
      case (b_phase)
        0: begin
          b_phase   <= 1;
          b_k       <= 0;
          core_load <= 1'b1;
        end
        1: begin
          cap_key[8*(15-b_k) +: 8]  <= core_key_byte;
          cap_text[8*(15-b_k) +: 8] <= core_state_byte;
          if (b_k == 15) begin
            b_phase   <= 2;
            b_t       <= 0;
            core_load <= 1'b0;
            b_res     <= core_cipher({cap_key[127:8], core_key_byte},
                                     {cap_text[127:8], core_state_byte});
          end else begin
            b_k <= b_k + 1;
          end
        end
        2: begin
          b_t <= b_t + 1;
          if (b_t == 1) core_ready <= 1'b0;
          if (b_t == LAT && !never_ready) begin
            core_ready <= 1'b1;
            b_phase    <= 3;
            b_k        <= 0;
          end
        end
        default: begin
          if (b_k < 16) begin
            core_state_out_byte <= b_res[8*(15-b_k) +: 8];
            b_k <= b_k + 1;
          end else if (b_k == 16) begin
            b_k <= 17;
          end else begin
            b_restarts <= b_restarts + 1;
            b_phase    <= 1;
            b_k        <= 0;
            core_load  <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- monitors ----------------
  logic [127:0] q_out[$];
  int low_run = 0;
  int min_low = 1000;
  bit seen_high = 1'b0;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) q_out.push_back(out_data);
  end

  always @(posedge clk) begin
    if (core_enable) begin
      if (seen_high && low_run > 0 && low_run < min_low) min_low <= low_run;
      seen_high <= 1'b1;
      low_run   <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic send(input string tag, input logic [127:0] k, input logic [127:0] t);
    wait_ready(tag);
    in_key   = k;
    in_text  = t;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [127:0] exp);
    int n = 0;
    while (q_out.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_arrived"}, q_out.size() != 0, 1);
    if (q_out.size() != 0) check(tag, q_out.pop_front(), exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [135:0] seq_k;
    logic [135:0] seq_t;
    logic [127:0] exp;
    logic [127:0] vk [3];
    logic [127:0] vt [3];
    bit           stable;
    int           n;

    // Reset values while reset is held.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags", {in_ready, out_valid, busy, err, core_enable}, 0);
    check("rst_buses", {core_key_byte, core_state_byte}, 0);
    check("rst_out_data", out_data, 0);

    // Reset GAP: in_ready rises GAP edges after release.
    rst_n = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_gap_len", n, GAP);
    check("rst_gap_enable", core_enable, 0);

    // FIPS-197 vector with byte-bus timing.
    send("fips", FIPS_KEY, FIPS_TEXT);
    check("fips_busy_inready", {busy, in_ready}, 2'b10);
    seq_k = '0;
    seq_t = '0;
    for (int i = 0; i < 17; i++) begin
      seq_k = {seq_k[127:0], core_key_byte};
      seq_t = {seq_t[127:0], core_state_byte};
      if (i < 16) @(negedge clk);
    end
    check("fips_key_bus_seq", seq_k, {8'h00, FIPS_KEY});
    check("fips_text_bus_seq", seq_t, {8'h00, FIPS_TEXT});
    wait_result("fips_ct", FIPS_CT);
    check("fips_cap_key", cap_key, FIPS_KEY);
    check("fips_cap_text", cap_text, FIPS_TEXT);
    repeat (5) @(negedge clk);
    check("fips_single_valid", {q_out.size() != 0, out_valid}, 0);

    // Backpressure: result held with enable low for 20 cycles.
    out_ready = 1'b0;
    vk[0] = 128'h00112233445566778899aabbccddeeff;
    vt[0] = 128'h0123456789abcdeffedcba9876543210;
    send("bp", vk[0], vt[0]);
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    exp = core_cipher(vk[0], vt[0]);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === exp && core_enable === 1'b0 && in_ready === 1'b0))
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_data", out_data, exp);
    out_ready = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_gap_len", n, GAP);
    check("bp_result", q_out.size() == 1 ? q_out.pop_front() : 128'h0, exp);

    // Stale ready carried from one block into the next LOAD.
    stale_mode = 1'b1;
    vk[1] = 128'hfedcba98765432100123456789abcdef;
    vt[1] = 128'h0f0e0d0c0b0a09080706050403020100;
    send("stale_a", vk[1], vt[1]);
    wait_result("stale_a_ct", core_cipher(vk[1], vt[1]));
    send("stale_b", FIPS_KEY, FIPS_TEXT);
    check("stale_b_ready_high", core_ready, 1);
    wait_result("stale_b_ct", FIPS_CT);
    stale_mode = 1'b0;

    // Back-to-back, in_valid held high across three blocks.
    vk[0] = 128'h11111111_22222222_33333333_44444444;
    vt[0] = 128'h55555555_66666666_77777777_88888888;
    vk[1] = 128'h0;
    vt[1] = 128'h11111111_11111111_22222222_22222222;
    vk[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    vt[2] = 128'ha0a1a2a3_a4a5a6a7_a8a9aaab_acadaeaf;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b");
      in_key   = vk[i];
      in_text  = vt[i];
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_result("b2b_0", core_cipher(vk[0], vt[0]));
    wait_result("b2b_1", 128'h78787878_78787878_4b4b4b4b_4b4b4b4b);
    wait_result("b2b_2", core_cipher(vk[2], vt[2]));
    check("b2b_min_enable_low", min_low >= GAP, 1);

    // Reset mid-DRAIN with seven bytes stored, then a fresh block.
    send("abort", vk[2], vt[2]);
    n = 0;
    while (!(b_phase == 3 && b_k == 8) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_drain", (b_phase == 3 && b_k == 8), 1);
    rst_n = 1'b0;
    #1;
    check("abort_async_clear", {out_valid, core_enable, busy, in_ready, out_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send("after_abort", vk[0], vt[0]);
    wait_result("after_abort_ct", core_cipher(vk[0], vt[0]));
    repeat (3) @(negedge clk);
    check("abort_no_extra_valid", q_out.size(), 0);

`ifdef AES_DRV_TIMEOUT_EN
    // Core never answers: err pulses TIMEOUT cycles into WAIT.
    never_ready = 1'b1;
    wait_ready("to");
    in_key   = vk[1];
    in_text  = vt[1];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("to_err_time", n, 17 + TO);
    check("to_enable_dropped", core_enable, 0);
    @(negedge clk);
    check("to_err_one_cycle", err, 0);
    never_ready = 1'b0;
    wait_ready("to_back_idle");
    check("to_no_valid", q_out.size(), 0);
`else
    check("err_tied_low", err, 0);
`endif

    check("no_core_restart", b_restarts, 0);
    check("min_enable_low", min_low >= GAP, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
